// File: rtl/s_axi_kernel_cfg.sv
// AXI4-Lite slave holding a shadow bank of convolution kernel weights that is
// published atomically to the datapath over a valid/ready stream on commit.
module s_axi_kernel_cfg #(
  parameter int unsigned ELEM_W      = 8,
  parameter int unsigned KSIZE       = 3,
  parameter int unsigned NUM_KERNELS = 1,
  parameter int unsigned ADDR_W      = 12
) (
  input  logic                                       clk,
  input  logic                                       rstn,
  input  logic [ADDR_W-1:0]                          s_axi_awaddr,
  input  logic [2:0]                                 s_axi_awprot,
  input  logic                                       s_axi_awvalid,
  output logic                                       s_axi_awready,
  input  logic [31:0]                                s_axi_wdata,
  input  logic [3:0]                                 s_axi_wstrb,
  input  logic                                       s_axi_wvalid,
  output logic                                       s_axi_wready,
  output logic [1:0]                                 s_axi_bresp,
  output logic                                       s_axi_bvalid,
  input  logic                                       s_axi_bready,
  input  logic [ADDR_W-1:0]                          s_axi_araddr,
  input  logic [2:0]                                 s_axi_arprot,
  input  logic                                       s_axi_arvalid,
  output logic                                       s_axi_arready,
  output logic [31:0]                                s_axi_rdata,
  output logic [1:0]                                 s_axi_rresp,
  output logic                                       s_axi_rvalid,
  input  logic                                       s_axi_rready,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [NUM_KERNELS*KSIZE*KSIZE*ELEM_W-1:0]  out_data
);

  localparam int unsigned N         = NUM_KERNELS * KSIZE * KSIZE;
  localparam int unsigned IDX_W     = ADDR_W - 2;
  localparam int unsigned ELEM_BASE = 32'h40;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] ID_VALUE  = {8'(KSIZE), 8'(NUM_KERNELS), 8'(ELEM_W), 8'h01};

  typedef enum logic [2:0] {REG_CTRL, REG_STATUS, REG_ID, REG_ELEM, REG_NONE} reg_sel_e;
  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA} rstate_e;

  function automatic reg_sel_e decode(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] off;
    off = idx - IDX_W'(ELEM_BASE);
    if (idx == IDX_W'(0)) return REG_CTRL;
    if (idx == IDX_W'(1)) return REG_STATUS;
    if (idx == IDX_W'(2)) return REG_ID;
    if (idx >= IDX_W'(ELEM_BASE) && off < IDX_W'(N)) return REG_ELEM;
    return REG_NONE;
  endfunction

  // Byte-lane merge into the zero-extended element, truncated back to ELEM_W.
  function automatic logic [ELEM_W-1:0] merge_elem(input logic [ELEM_W-1:0] old,
                                                   input logic [31:0] d,
                                                   input logic [3:0] s);
    logic [31:0] r;
    r = 32'(old);
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r[ELEM_W-1:0];
  endfunction

  logic unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // First stage of the reset release; the ready flops act as the second stage.
  logic rst_sync_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) rst_sync_q <= 1'b0;
    else       rst_sync_q <= 1'b1;

  // ---------------- write channel ----------------
  wstate_e          wstate, wstate_n;
  logic             aw_held, w_held, aw_held_n, w_held_n;
  logic             awready_n, wready_n, bvalid_n;
  logic             aw_hs, w_hs;
  logic [IDX_W-1:0] waddr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wstate        <= W_IDLE;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
    end else begin
      wstate        <= wstate_n;
      aw_held       <= aw_held_n;
      w_held        <= w_held_n;
      s_axi_awready <= awready_n;
      s_axi_wready  <= wready_n;
      s_axi_bvalid  <= bvalid_n;
    end

  always_comb begin
    wstate_n  = wstate;
    aw_held_n = aw_held;
    w_held_n  = w_held;
    case (wstate)
      W_IDLE: begin
        if (aw_hs) aw_held_n = 1'b1;
        if (w_hs)  w_held_n  = 1'b1;
        if (aw_held_n && w_held_n) wstate_n = W_EXEC;
      end
      W_EXEC: wstate_n = W_RESP;
      W_RESP: if (s_axi_bready) begin
        wstate_n  = W_IDLE;
        aw_held_n = 1'b0;
        w_held_n  = 1'b0;
      end
      default: wstate_n = W_IDLE;
    endcase
    awready_n = (wstate_n == W_IDLE) && !aw_held_n && rst_sync_q;
    wready_n  = (wstate_n == W_IDLE) && !w_held_n && rst_sync_q;
    bvalid_n  = (wstate_n == W_RESP);
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      waddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      if (aw_hs) waddr_q <= s_axi_awaddr[ADDR_W-1:2];
      if (w_hs) begin
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
    end

  // ---------------- write execution and output bank ----------------
  logic [N-1:0][ELEM_W-1:0] shadow;
  logic [15:0]              commit_cnt;
  reg_sel_e                 w_sel;
  logic [IDX_W-1:0]         w_off;
  logic exec, do_commit, do_clear, commit_ok, w_err, commit_fire, clear_fire;

  assign exec        = (wstate == W_EXEC);
  assign w_sel       = decode(waddr_q);
  assign w_off       = waddr_q - IDX_W'(ELEM_BASE);
  assign do_commit   = wstrb_q[0] & wdata_q[0];
  assign do_clear    = wstrb_q[0] & wdata_q[1];
  assign commit_ok   = !out_valid || out_ready;
  assign w_err       = (w_sel == REG_NONE) || (w_sel == REG_STATUS) || (w_sel == REG_ID) ||
                       ((w_sel == REG_CTRL) && do_commit && !commit_ok);
  assign commit_fire = exec && (w_sel == REG_CTRL) && do_commit && commit_ok;
  assign clear_fire  = exec && (w_sel == REG_CTRL) && do_clear && !w_err;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      shadow      <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      commit_cnt  <= '0;
      s_axi_bresp <= RESP_OKAY;
    end else begin
      if (exec) s_axi_bresp <= w_err ? RESP_SLVERR : RESP_OKAY;
      if (clear_fire) begin
        shadow <= '0;
      end else if (exec && (w_sel == REG_ELEM)) begin
        for (int unsigned j = 0; j < N; j++)
          if (w_off == IDX_W'(j)) shadow[j] <= merge_elem(shadow[j], wdata_q, wstrb_q);
      end
      // A commit landing in the consume cycle keeps out_valid high with new data.
      if (commit_fire) begin
        out_data   <= clear_fire ? '0 : shadow;
        out_valid  <= 1'b1;
        commit_cnt <= commit_cnt + 16'd1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end

  // ---------------- read channel ----------------
  rstate_e          rstate, rstate_n;
  logic             arready_n, rvalid_n, ar_hs;
  logic [IDX_W-1:0] ar_idx, ar_off;
  reg_sel_e         ar_sel;
  logic [ELEM_W-1:0] rd_elem;
  logic [31:0]      rd_data;
  logic [1:0]       rd_resp;

  assign ar_hs  = s_axi_arvalid & s_axi_arready;
  assign ar_idx = s_axi_araddr[ADDR_W-1:2];
  assign ar_off = ar_idx - IDX_W'(ELEM_BASE);
  assign ar_sel = decode(ar_idx);

  always_comb begin
    rd_elem = '0;
    for (int unsigned j = 0; j < N; j++)
      if (ar_off == IDX_W'(j)) rd_elem = shadow[j];
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (ar_sel)
      REG_STATUS: rd_data = {commit_cnt, 15'd0, out_valid};
      REG_ID:     rd_data = ID_VALUE;
      REG_ELEM:   rd_data = 32'(rd_elem);
      REG_NONE:   rd_resp = RESP_SLVERR;
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      rstate        <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
    end else begin
      rstate        <= rstate_n;
      s_axi_arready <= arready_n;
      s_axi_rvalid  <= rvalid_n;
    end

  always_comb begin
    rstate_n = rstate;
    case (rstate)
      R_IDLE:  if (ar_hs) rstate_n = R_DATA;
      R_DATA:  if (s_axi_rready) rstate_n = R_IDLE;
      default: rstate_n = R_IDLE;
    endcase
    arready_n = (rstate_n == R_IDLE) && rst_sync_q;
    rvalid_n  = (rstate_n == R_DATA);
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
    end else if (ar_hs) begin
      s_axi_rdata <= rd_data;
      s_axi_rresp <= rd_resp;
    end

endmodule

// File: tb/tb_s_axi_kernel_cfg.sv
// Directed self-checking bench for s_axi_kernel_cfg (3x3x8-bit, one kernel).
module tb_s_axi_kernel_cfg;

  logic        clk = 1'b0;
  logic        rstn;
  logic [11:0] s_axi_awaddr;
  logic [2:0]  s_axi_awprot;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [11:0] s_axi_araddr;
  logic [2:0]  s_axi_arprot;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic        out_valid;
  logic        out_ready;
  logic [71:0] out_data;

  int checks = 0;
  int errors = 0;

  s_axi_kernel_cfg #(.ELEM_W(8), .KSIZE(3), .NUM_KERNELS(1), .ADDR_W(12)) dut (
    .clk(clk), .rstn(rstn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full write with AW and W presented together; samples out_* in the first bvalid cycle.
  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic ov, output logic [71:0] od);
    int n;
    s_axi_awaddr  = a;
    s_axi_wdata   = d;
    s_axi_wstrb   = s;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(s_axi_awready && s_axi_wready) && n < 50) begin @(negedge clk); n++; end
    check("wr_ready_wait", {s_axi_awready, s_axi_wready}, 2'b11);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    n = 0;
    @(negedge clk);
    while (!s_axi_bvalid && n < 50) begin @(negedge clk); n++; end
    check("bvalid_wait", s_axi_bvalid, 1'b1);
    resp = s_axi_bresp;
    ov   = out_valid;
    od   = out_data;
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    s_axi_araddr  = a;
    s_axi_arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_axi_arready && n < 50) begin @(negedge clk); n++; end
    check("arready_wait", s_axi_arready, 1'b1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!s_axi_rvalid && n < 50) begin @(negedge clk); n++; end
    check("rvalid_wait", s_axi_rvalid, 1'b1);
    d    = s_axi_rdata;
    resp = s_axi_rresp;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [1:0]  resp;
    logic        ov;
    logic [71:0] od;
    logic [31:0] rd;
    int          n;

    rstn = 1'b1;
    s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
    s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    out_ready = 1'b0;

    // Reset: every output low, ready rises on the 2nd edge after release
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid,
                            s_axi_rvalid, out_valid, s_axi_bresp, s_axi_rresp, s_axi_rdata}, '0);
    check("reset_out_data", out_data, '0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("ready_edge1", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
    @(posedge clk); #1;
    check("ready_edge2", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

    axi_read(12'h008, rd, resp);
    check("id_read", {rd, resp}, {32'h03010801, 2'b00});
    axi_read(12'h004, rd, resp);
    check("status_reset", {rd, resp}, {32'h0, 2'b00});

    // Load elements 0..8 and publish with out_ready high
    for (int j = 0; j < 9; j++) begin
      axi_write(12'h100 + 12'(4 * j), 32'(8'h11 * (j + 1)), 4'hF, resp, ov, od);
      check("elem_write_resp", resp, 2'b00);
    end
    axi_read(12'h110, rd, resp);
    check("elem4_read", {rd, resp}, {32'h55, 2'b00});
    out_ready = 1'b1;
    axi_write(12'h000, 32'h1, 4'hF, resp, ov, od);
    check("commit1_resp", resp, 2'b00);
    check("commit1_valid", ov, 1'b1);
    check("commit1_data", od, 72'h998877665544332211);
    check("commit1_pulse_end", out_valid, 1'b0);
    axi_read(12'h004, rd, resp);
    check("status_cnt1", rd, 32'h0001_0000);

    // W three cycles ahead of AW, strobe on a lane above ELEM_W
    s_axi_awaddr = 12'h100; s_axi_wdata = 32'h0000_AB00; s_axi_wstrb = 4'b0010;
    s_axi_wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_axi_wready && n < 50) begin @(negedge clk); n++; end
    check("early_w_ready", s_axi_wready, 1'b1);
    @(posedge clk); #1;
    s_axi_wvalid = 1'b0;
    check("early_w_held", {s_axi_awready, s_axi_wready}, 2'b10);
    @(posedge clk);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b1;
    @(negedge clk);
    check("late_aw_ready", s_axi_awready, 1'b1);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    check("bvalid_hs_plus1", s_axi_bvalid, 1'b0);
    @(posedge clk); #1;
    check("bvalid_hs_plus2", {s_axi_bvalid, s_axi_bresp}, {1'b1, 2'b00});
    @(posedge clk); #1;
    check("bvalid_after_bready", s_axi_bvalid, 1'b0);
    axi_read(12'h100, rd, resp);
    check("strb_lane1_elem0", rd, 32'h11);

    // Back-pressure: second commit refused, data held
    out_ready = 1'b0;
    axi_write(12'h000, 32'h1, 4'hF, resp, ov, od);
    check("bp_commit_ok", {resp, ov}, {2'b00, 1'b1});
    check("bp_commit_data", od, 72'h998877665544332211);
    axi_write(12'h100, 32'h5A, 4'hF, resp, ov, od);
    check("elem0_rewrite", resp, 2'b00);
    axi_write(12'h000, 32'h1, 4'hF, resp, ov, od);
    check("bp_commit_refused", resp, 2'b10);
    check("bp_data_unchanged", {ov, od}, {1'b1, 72'h998877665544332211});
    out_ready = 1'b1;
    axi_write(12'h000, 32'h1, 4'hF, resp, ov, od);
    check("commit_after_ready", {resp, ov}, {2'b00, 1'b1});
    check("commit_after_ready_data", od, 72'h99887766554433225A);
    axi_read(12'h004, rd, resp);
    check("status_cnt3", rd, 32'h0003_0000);

    // Bad accesses
    axi_write(12'h00C, 32'hFFFF_FFFF, 4'hF, resp, ov, od);
    check("wr_unmapped", resp, 2'b10);
    axi_write(12'h004, 32'hFFFF_FFFF, 4'hF, resp, ov, od);
    check("wr_status", resp, 2'b10);
    axi_write(12'h124, 32'h77, 4'hF, resp, ov, od);
    check("wr_past_bank", resp, 2'b10);
    axi_read(12'h004, rd, resp);
    check("status_unchanged", rd, 32'h0003_0000);
    axi_read(12'h2FC, rd, resp);
    check("rd_unmapped", {rd, resp}, {32'h0, 2'b10});
    axi_read(12'h120, rd, resp);
    check("elem8_read", rd, 32'h99);

    // CLEAR together with COMMIT publishes zeros
    axi_write(12'h000, 32'h3, 4'hF, resp, ov, od);
    check("clear_commit", {resp, ov, od}, {2'b00, 1'b1, 72'h0});
    axi_read(12'h10C, rd, resp);
    check("elem3_cleared", rd, 32'h0);

    // Counter wrap from a preloaded value
    force dut.commit_cnt = 16'hFFFE;
    @(posedge clk); #1;
    release dut.commit_cnt;
    axi_write(12'h000, 32'h1, 4'hF, resp, ov, od);
    axi_read(12'h004, rd, resp);
    check("status_cnt_ffff", rd, 32'hFFFF_0000);
    axi_write(12'h000, 32'h1, 4'hF, resp, ov, od);
    axi_read(12'h004, rd, resp);
    check("status_cnt_wrap", rd, 32'h0000_0000);

    // Reset in the middle of a write response
    out_ready = 1'b0;
    axi_write(12'h000, 32'h1, 4'hF, resp, ov, od);
    check("pre_abort_commit", {resp, ov}, {2'b00, 1'b1});
    s_axi_bready = 1'b0;
    s_axi_awaddr = 12'h108; s_axi_wdata = 32'h77; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(s_axi_awready && s_axi_wready) && n < 50) begin @(negedge clk); n++; end
    check("abort_wr_ready", {s_axi_awready, s_axi_wready}, 2'b11);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!s_axi_bvalid && n < 50) begin @(negedge clk); n++; end
    check("abort_bvalid_held", {s_axi_bvalid, out_valid}, 2'b11);
    rstn = 1'b0;
    #1;
    check("abort_outputs", {s_axi_bvalid, s_axi_rvalid, out_valid,
                            s_axi_awready, s_axi_wready, s_axi_arready}, 6'b0);
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    axi_read(12'h108, rd, resp);
    check("abort_elem2_zero", rd, 32'h0);
    axi_read(12'h120, rd, resp);
    check("abort_elem8_zero", rd, 32'h0);
    axi_read(12'h004, rd, resp);
    check("abort_status_zero", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
